// File: rtl/conv_pkg.sv
// Shared constants, size helpers and FSM encoding for the streaming convolution layer.
package conv_pkg;
  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_IMAGE_WIDTH = 10;
  localparam int DEF_POF         = 4;
  localparam int DEF_NKX         = 3;
  localparam int DEF_NKY         = 3;

  function automatic int calcResultWidth(input int dataWidth);
    return 2 * dataWidth + 1;
  endfunction

  function automatic int calcWarmup(input int imageWidth, input int nkx, input int nky);
    return (nky - 1) * imageWidth + (nkx - 1);
  endfunction

  localparam int RESULT_WIDTH  = calcResultWidth(DEF_DATA_WIDTH);
  localparam int TOTAL_WEIGHTS = DEF_POF * DEF_NKX * DEF_NKY;
  localparam int WARMUP        = calcWarmup(DEF_IMAGE_WIDTH, DEF_NKX, DEF_NKY);
  localparam int TOTAL_PIXELS  = DEF_IMAGE_WIDTH * DEF_IMAGE_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;
endpackage

// File: rtl/conv_window_gen.sv
// Sliding NKX x NKY window over a raster pixel stream: input register, circular line buffers,
// window shift registers and a window-valid flag that masks the warm-up pixels of each frame.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int IMAGE_WIDTH = DEF_IMAGE_WIDTH,
  parameter int NKX         = DEF_NKX,
  parameter int NKY         = DEF_NKY,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   clear_i,
  input  logic                                   pixelValid_i,
  input  logic [DATA_WIDTH-1:0]                  pixelData_i,
  output logic [COUNT_WIDTH-1:0]                 pixelCount_o,
  output logic                                   busy_o,
  output logic                                   windowValid_o,
  output logic [NKY-1:0][NKX-1:0][DATA_WIDTH-1:0] window_o
);
  localparam int PTR_WIDTH = $clog2(IMAGE_WIDTH);
  localparam logic [COUNT_WIDTH-1:0] WARMUP_IDX = COUNT_WIDTH'(calcWarmup(IMAGE_WIDTH, NKX, NKY));
  localparam logic [PTR_WIDTH-1:0]   PTR_LAST   = PTR_WIDTH'(IMAGE_WIDTH - 1);

  logic [COUNT_WIDTH-1:0]                  pixCount_q;
  logic [COUNT_WIDTH-1:0]                  pixCount_d;
  logic [COUNT_WIDTH-1:0]                  pixIdx_q;
  logic                                    pixValid_q;
  logic [DATA_WIDTH-1:0]                   pixData_q;
  logic [DATA_WIDTH-1:0]                   lineBuf_q [NKY-1][IMAGE_WIDTH];
  logic [PTR_WIDTH-1:0]                    wrPtr_q;
  logic [PTR_WIDTH-1:0]                    wrPtr_d;
  logic [NKY-1:0][NKX-1:0][DATA_WIDTH-1:0] window_q;
  logic                                    windowValid_q;
  logic [NKY-1:0][DATA_WIDTH-1:0]          tap;

  always_comb begin
    pixCount_d = pixCount_q;
    if (clear_i) begin
      pixCount_d = '0;
    end else if (pixelValid_i) begin
      pixCount_d = pixCount_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pixCount_q <= '0;
      pixIdx_q   <= '0;
      pixValid_q <= 1'b0;
      pixData_q  <= '0;
    end else begin
      pixCount_q <= pixCount_d;
      pixValid_q <= pixelValid_i;
      if (pixelValid_i) begin
        pixData_q <= pixelData_i;
        pixIdx_q  <= pixCount_q;
      end
    end
  end

  // tap[ky] is the pixel (NKY-1-ky) rows above the newest one; each buffer reads before it overwrites.
  always_comb begin
    tap          = '0;
    tap[NKY-1]   = pixData_q;
    for (int j = 0; j < NKY - 1; j++) begin
      tap[j] = lineBuf_q[j][wrPtr_q];
    end
  end

  assign wrPtr_d = (wrPtr_q == PTR_LAST) ? '0 : wrPtr_q + PTR_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NKY - 1; j++) begin
        for (int i = 0; i < IMAGE_WIDTH; i++) begin
          lineBuf_q[j][i] <= '0;
        end
      end
      wrPtr_q       <= '0;
      window_q      <= '0;
      windowValid_q <= 1'b0;
    end else begin
      windowValid_q <= pixValid_q && (pixIdx_q >= WARMUP_IDX);
      if (pixValid_q) begin
        for (int j = 0; j < NKY - 1; j++) begin
          lineBuf_q[j][wrPtr_q] <= tap[j+1];
        end
        wrPtr_q <= wrPtr_d;
        for (int ky = 0; ky < NKY; ky++) begin
          for (int kx = 0; kx < NKX - 1; kx++) begin
            window_q[ky][kx] <= window_q[ky][kx+1];
          end
          window_q[ky][NKX-1] <= tap[ky];
        end
      end
    end
  end

  assign pixelCount_o  = pixCount_q;
  assign busy_o        = pixValid_q | windowValid_q;
  assign windowValid_o = windowValid_q;
  assign window_o      = window_q;
endmodule

// File: rtl/conv_layer_top.sv
// Streaming 2-D convolution layer: weight RAM, POF parallel multiply/adder-tree pipelines and the
// frame FSM around the sliding-window generator.
module conv_layer_top
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int IMAGE_WIDTH = DEF_IMAGE_WIDTH,
  parameter int POF         = DEF_POF,
  parameter int NKX         = DEF_NKX,
  parameter int NKY         = DEF_NKY,
  parameter int PIX         = 1,
  parameter int PIY         = 1
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          start,
  output logic                                          done,
  input  logic                                          load_weights,
  input  logic [DATA_WIDTH-1:0]                         weight_in,
  input  logic [$clog2(POF*NKX*NKY)-1:0]                weight_addr,
  input  logic                                          pixel_valid_in,
  input  logic [DATA_WIDTH-1:0]                         pixel_data_in,
  output logic                                          output_valid_out,
  output logic [POF*PIX*PIY*(2*DATA_WIDTH+1)-1:0]       results_data_flat
);
  localparam int RW          = calcResultWidth(DATA_WIDTH);
  localparam int PW          = 2 * DATA_WIDTH;
  localparam int NTAPS       = NKX * NKY;
  localparam int NW          = POF * NTAPS;
  localparam int TOTAL_PIX   = IMAGE_WIDTH * IMAGE_WIDTH;
  localparam int COUNT_WIDTH = $clog2(TOTAL_PIX + 1);
  localparam logic [COUNT_WIDTH-1:0] LAST_PIX = COUNT_WIDTH'(TOTAL_PIX - 1);

  state_e                                  state_q;
  state_e                                  state_d;
  logic                                    frameClear;
  logic                                    pixelAccept;
  logic                                    weightWrEn;
  logic [COUNT_WIDTH-1:0]                  pixCount;
  logic                                    winBusy;
  logic                                    winValid;
  logic [NKY-1:0][NKX-1:0][DATA_WIDTH-1:0] window;
  logic [NW-1:0][DATA_WIDTH-1:0]           weight_q;
  logic [POF-1:0][NTAPS-1:0][PW-1:0]       prod_q;
  logic [POF-1:0][NTAPS-1:0][PW-1:0]       prod_d;
  logic                                    mulValid_q;
  logic [POF-1:0][RW-1:0]                  sum_d;
  logic [POF*PIX*PIY*RW-1:0]               results_q;
  logic                                    outValid_q;

  assign pixelAccept = (state_q == RUN) && pixel_valid_in;
  assign weightWrEn  = load_weights && ((state_q == IDLE) || (state_q == DONE)) &&
                       (int'(weight_addr) < NW);

  conv_window_gen #(
    .DATA_WIDTH  (DATA_WIDTH),
    .IMAGE_WIDTH (IMAGE_WIDTH),
    .NKX         (NKX),
    .NKY         (NKY),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_window (
    .clk           (clk),
    .rst           (rst),
    .clear_i       (frameClear),
    .pixelValid_i  (pixelAccept),
    .pixelData_i   (pixel_data_in),
    .pixelCount_o  (pixCount),
    .busy_o        (winBusy),
    .windowValid_o (winValid),
    .window_o      (window)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      weight_q <= '0;
    end else if (weightWrEn) begin
      weight_q[weight_addr] <= weight_in;
    end
  end

  // Operands are sign-extended to the product width so the multiply is exact in PW bits.
  always_comb begin
    prod_d = '0;
    for (int f = 0; f < POF; f++) begin
      for (int ky = 0; ky < NKY; ky++) begin
        for (int kx = 0; kx < NKX; kx++) begin
          prod_d[f][ky*NKX+kx] =
            $signed({{DATA_WIDTH{window[ky][kx][DATA_WIDTH-1]}}, window[ky][kx]}) *
            $signed({{DATA_WIDTH{weight_q[f*NTAPS+ky*NKX+kx][DATA_WIDTH-1]}},
                     weight_q[f*NTAPS+ky*NKX+kx]});
        end
      end
    end
  end

  always_comb begin
    sum_d = '0;
    for (int f = 0; f < POF; f++) begin
      for (int t = 0; t < NTAPS; t++) begin
        sum_d[f] = sum_d[f] + {{(RW-PW){prod_q[f][t][PW-1]}}, prod_q[f][t]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q     <= '0;
      mulValid_q <= 1'b0;
      results_q  <= '0;
      outValid_q <= 1'b0;
    end else begin
      mulValid_q <= winValid;
      if (winValid) begin
        prod_q <= prod_d;
      end
      outValid_q <= mulValid_q;
      if (mulValid_q) begin
        for (int f = 0; f < POF; f++) begin
          results_q[f*RW +: RW] <= sum_d[f];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // DONE waits for start to drop so a held start cannot launch a second frame.
  always_comb begin
    state_d    = state_q;
    frameClear = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          frameClear = 1'b1;
        end
      end
      RUN: begin
        if (pixelAccept && (pixCount == LAST_PIX)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!(winBusy || mulValid_q)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!start) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign done              = (state_q == DONE);
  assign output_valid_out  = outValid_q;
  assign results_data_flat = results_q;
endmodule

// File: tb/tb_conv_layer_top.sv
// Directed bench for conv_layer_top: reset values, full frames with hand-computed results,
// input gaps, post-frame flush with start held, writes while running and mid-frame reset.
module tb_conv_layer_top;
  import conv_pkg::*;

  localparam int DW   = DEF_DATA_WIDTH;
  localparam int RW   = RESULT_WIDTH;
  localparam int NF   = DEF_POF;
  localparam int NOUT = TOTAL_PIXELS - WARMUP;
  localparam int AW   = $clog2(TOTAL_WEIGHTS);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              done;
  logic              load_weights = 1'b0;
  logic [DW-1:0]     weight_in = '0;
  logic [AW-1:0]     weight_addr = '0;
  logic              pixel_valid_in = 1'b0;
  logic [DW-1:0]     pixel_data_in = '0;
  logic              output_valid_out;
  logic [NF*RW-1:0]  results_data_flat;

  always #5 clk = ~clk;

  conv_layer_top dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .done              (done),
    .load_weights      (load_weights),
    .weight_in         (weight_in),
    .weight_addr       (weight_addr),
    .pixel_valid_in    (pixel_valid_in),
    .pixel_data_in     (pixel_data_in),
    .output_valid_out  (output_valid_out),
    .results_data_flat (results_data_flat)
  );

  int               edgeCount = 0;
  logic [NF*RW-1:0] outData[$];
  int               outEdge[$];
  int               doneRise[$];
  logic             doneLast = 1'b0;
  int               frameBase = 0;
  int               doneBase = 0;
  int               accept22 = -1;
  int               passCount = 0;
  int               checkCount = 0;

  always @(posedge clk) edgeCount <= edgeCount + 1;

  always @(posedge clk) begin
    #1;
    if (output_valid_out === 1'b1) begin
      outData.push_back(results_data_flat);
      outEdge.push_back(edgeCount);
    end
    if (done === 1'b1 && !doneLast) doneRise.push_back(edgeCount);
    doneLast <= (done === 1'b1);
  end

  task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                             input logic signed [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end else begin
      passCount++;
    end
  endtask

  function automatic logic signed [RW-1:0] getRes(input logic [NF*RW-1:0] flat, input int f);
    return flat[f*RW +: RW];
  endfunction

  function automatic logic signed [63:0] expectedFor(input int testId, input int k, input int f);
    case (testId)
      2, 5:    return 64'sd45;
      3:       return (f == 2) ? 64'(k + 11) : 64'sd0;
      4:       return -64'sd294903;
      6:       return (f == 0) ? 64'(k) : ((f == 3) ? 64'(2 * (k + 22)) : 64'sd0);
      default: return 64'sd0;
    endcase
  endfunction

  task automatic loadWeight(input int addr, input logic [DW-1:0] val);
    @(negedge clk);
    load_weights = 1'b1;
    weight_addr  = AW'(addr);
    weight_in    = val;
    @(negedge clk);
    load_weights = 1'b0;
  endtask

  task automatic loadAllWeights(input logic [DW-1:0] val);
    for (int a = 0; a < TOTAL_WEIGHTS; a++) loadWeight(a, val);
  endtask

  task automatic applyStimulus(input bit useIndex, input logic [DW-1:0] pixVal, input bit gaps,
                               input int flushCount, input bit runWrite);
    int waitCycles;
    frameBase = outData.size();
    doneBase  = doneRise.size();
    accept22  = -1;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < TOTAL_PIXELS; i++) begin
      @(negedge clk);
      pixel_valid_in = 1'b1;
      pixel_data_in  = useIndex ? DW'(i) : pixVal;
      load_weights   = runWrite && (i == 10);
      weight_addr    = AW'(13);
      weight_in      = DW'(7);
      if (i == WARMUP) accept22 = edgeCount + 1;
      if (gaps) begin
        @(negedge clk);
        pixel_valid_in = 1'b0;
        pixel_data_in  = 16'h1234;
        load_weights   = 1'b0;
      end
    end
    @(negedge clk);
    load_weights   = 1'b0;
    pixel_valid_in = 1'b0;
    pixel_data_in  = '0;
    for (int j = 0; j < flushCount; j++) begin
      pixel_valid_in = 1'b1;
      @(negedge clk);
    end
    pixel_valid_in = 1'b0;
    waitCycles = 0;
    while (done !== 1'b1 && waitCycles < 100) begin
      @(negedge clk);
      waitCycles++;
    end
    if (done !== 1'b1) checkOutput("done_timeout", 64'(done), 64'sd1);
  endtask

  task automatic verifyFrame(input int testId);
    int n;
    int bad;
    n = outData.size() - frameBase;
    checkOutput($sformatf("t%0d_pulse_count", testId), 64'(n), 64'(NOUT));
    if (n > 0) begin
      checkOutput($sformatf("t%0d_first_latency", testId), 64'(outEdge[frameBase] - accept22), 64'sd3);
      checkOutput($sformatf("t%0d_first_f2", testId), getRes(outData[frameBase], 2),
                  expectedFor(testId, 0, 2));
      checkOutput($sformatf("t%0d_last_f0", testId), getRes(outData[outData.size()-1], 0),
                  expectedFor(testId, n - 1, 0));
    end
    if (doneRise.size() > doneBase && n > 0) begin
      checkOutput($sformatf("t%0d_done_latency", testId),
                  64'(doneRise[doneBase] - outEdge[outEdge.size()-1]), 64'sd1);
    end else begin
      checkOutput($sformatf("t%0d_done_seen", testId), 64'sd0, 64'sd1);
    end
    bad = 0;
    for (int k = 0; k < n; k++) begin
      for (int f = 0; f < NF; f++) begin
        if (getRes(outData[frameBase+k], f) !== expectedFor(testId, k, f)) bad++;
      end
    end
    checkOutput($sformatf("t%0d_bad_results", testId), 64'(bad), 64'sd0);
  endtask

  task automatic endFrame(input int testId);
    checkOutput($sformatf("t%0d_done_held", testId), 64'(done), 64'sd1);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput($sformatf("t%0d_back_idle", testId), 64'(done), 64'sd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] reset");
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_done", 64'(done), 64'sd0);
    checkOutput("reset_valid", 64'(output_valid_out), 64'sd0);
    checkOutput("reset_results_nonzero", 64'(|results_data_flat), 64'sd0);
    rst = 1'b0;

    $display("[TB] test 2: all-ones weights, constant 5, flush with start held");
    loadAllWeights(16'd1);
    applyStimulus(1'b0, 16'd5, 1'b0, 30, 1'b0);
    verifyFrame(2);
    endFrame(2);

    $display("[TB] test 3: centre tap on filter 2, index pixels, write attempted in RUN");
    loadAllWeights(16'd0);
    loadWeight(2 * 9 + 4, 16'd1);
    applyStimulus(1'b1, 16'd0, 1'b0, 0, 1'b1);
    verifyFrame(3);
    endFrame(3);

    $display("[TB] test 4: weights -1, pixels 32767");
    loadAllWeights(16'hFFFF);
    applyStimulus(1'b0, 16'h7FFF, 1'b0, 0, 1'b0);
    verifyFrame(4);
    endFrame(4);

    $display("[TB] test 5: gaps in pixel_valid_in");
    loadAllWeights(16'd1);
    applyStimulus(1'b0, 16'd5, 1'b1, 0, 1'b0);
    verifyFrame(5);
    endFrame(5);

    $display("[TB] test 6: corner taps check window orientation");
    loadAllWeights(16'd0);
    loadWeight(0, 16'd1);
    loadWeight(35, 16'd2);
    applyStimulus(1'b1, 16'd0, 1'b0, 0, 1'b0);
    verifyFrame(6);
    endFrame(6);

    $display("[TB] test 7: reset mid-frame clears outputs, counters and weights");
    loadAllWeights(16'd1);
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      pixel_valid_in = 1'b1;
      pixel_data_in  = 16'd5;
    end
    @(negedge clk);
    pixel_valid_in = 1'b0;
    checkOutput("t7_pre_reset_f1", getRes(results_data_flat, 1), 64'sd45);
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("t7_rst_valid", 64'(output_valid_out), 64'sd0);
    checkOutput("t7_rst_results_nonzero", 64'(|results_data_flat), 64'sd0);
    checkOutput("t7_rst_done", 64'(done), 64'sd0);
    rst = 1'b0;
    applyStimulus(1'b0, 16'd5, 1'b0, 0, 1'b0);
    verifyFrame(7);
    endFrame(7);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
